// File: rtl/pwm_cfg_sequencer.sv
// PWM configuration sequencer: shadows period/duty updates and commits them on period boundaries.
// Optional build macro PWM_CFG_SEQ_OVERWRITE_EN keeps cfg_ready high while an update is pending (last write wins).
module pwm_cfg_sequencer #(
    parameter int unsigned CNT_WIDTH             = 32,
    parameter int unsigned DEFAULT_PERIOD_CYCLES = 5000,
    parameter int unsigned DEFAULT_DUTY_CYCLES   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_req,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    input  logic                 period_end,
    output logic                 tb_enable,
    output logic [CNT_WIDTH-1:0] period_cycles,
    output logic [CNT_WIDTH-1:0] duty_cycles,
    output logic                 update_pending,
    output logic                 update_done
);

    localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] DEF_DUTY   = CNT_WIDTH'(DEFAULT_DUTY_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MIN_PERIOD = CNT_WIDTH'(2);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_WIDTH-1:0] shadow_period;
    logic [CNT_WIDTH-1:0] shadow_duty;

    logic                 accept;
    logic                 commit;
    logic                 load_shadow;
    logic [CNT_WIDTH-1:0] src_period;
    logic [CNT_WIDTH-1:0] src_duty;
    logic                 ready_nx;

    // Duty never exceeds the period the timebase will actually run (0 -> default, 1 -> 2).
    function automatic logic [CNT_WIDTH-1:0] clamp_duty(input logic [CNT_WIDTH-1:0] period,
                                                        input logic [CNT_WIDTH-1:0] duty);
        logic [CNT_WIDTH-1:0] eff;
        if (period == '0) begin
            eff = DEF_PERIOD;
        end else if (period < MIN_PERIOD) begin
            eff = MIN_PERIOD;
        end else begin
            eff = period;
        end
        return (duty > eff) ? eff : duty;
    endfunction

    assign accept = cfg_valid && cfg_ready;

    // Next state and commit source selection.
    always_comb begin
        state_nx    = state;
        commit      = 1'b0;
        load_shadow = 1'b0;
        src_period  = shadow_period;
        src_duty    = shadow_duty;

        case (state)
            STOPPED: begin
                if (accept) begin
                    commit     = 1'b1;
                    src_period = cfg_period;
                    src_duty   = cfg_duty;
                end
                if (enable_req) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!enable_req) begin
                    state_nx = STOPPED;
                    if (accept) begin
                        commit     = 1'b1;
                        src_period = cfg_period;
                        src_duty   = cfg_duty;
                    end
                end else if (accept) begin
                    load_shadow = 1'b1;
                    state_nx    = PENDING;
                end
            end
            PENDING: begin
`ifdef PWM_CFG_SEQ_OVERWRITE_EN
                if (accept) begin
                    load_shadow = 1'b1;
                    src_period  = cfg_period;
                    src_duty    = cfg_duty;
                end
`endif
                if (!enable_req) begin
                    commit   = 1'b1;
                    state_nx = STOPPED;
                end else if (period_end) begin
                    commit   = 1'b1;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = STOPPED;
            end
        endcase
    end

`ifdef PWM_CFG_SEQ_OVERWRITE_EN
    assign ready_nx = 1'b1;
`else
    assign ready_nx = (state_nx != PENDING);
`endif

    // State, shadow and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= STOPPED;
            shadow_period  <= DEF_PERIOD;
            shadow_duty    <= DEF_DUTY;
            period_cycles  <= DEF_PERIOD;
            duty_cycles    <= DEF_DUTY;
            tb_enable      <= 1'b0;
            cfg_ready      <= 1'b1;
            update_pending <= 1'b0;
            update_done    <= 1'b0;
        end else begin
            state          <= state_nx;
            tb_enable      <= (state_nx != STOPPED);
            cfg_ready      <= ready_nx;
            update_pending <= (state_nx == PENDING);
            update_done    <= commit;
            if (load_shadow) begin
                shadow_period <= cfg_period;
                shadow_duty   <= cfg_duty;
            end
            if (commit) begin
                period_cycles <= src_period;
                duty_cycles   <= clamp_duty(src_period, src_duty);
            end
        end
    end

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Self-checking bench for pwm_cfg_sequencer: scoreboard of expected commits plus per-scenario checks.
module tb_pwm_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_req = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_period = '0;
    logic [31:0] cfg_duty = '0;
    logic        period_end = 1'b0;
    logic        tb_enable;
    logic [31:0] period_cycles;
    logic [31:0] duty_cycles;
    logic        update_pending;
    logic        update_done;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] duty;
    } cfg_t;

    cfg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef PWM_CFG_SEQ_OVERWRITE_EN
    localparam logic PEND_READY = 1'b1;
`else
    localparam logic PEND_READY = 1'b0;
`endif

    pwm_cfg_sequencer #(
        .CNT_WIDTH(32),
        .DEFAULT_PERIOD_CYCLES(5000),
        .DEFAULT_DUTY_CYCLES(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable_req(enable_req),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_period(cfg_period),
        .cfg_duty(cfg_duty),
        .period_end(period_end),
        .tb_enable(tb_enable),
        .period_cycles(period_cycles),
        .duty_cycles(duty_cycles),
        .update_pending(update_pending),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    // Every update_done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        if (!rst && update_done) begin
            cfg_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update_done: got period=%0d duty=%0d, none expected",
                         period_cycles, duty_cycles);
            end else begin
                e = exp_q.pop_front();
                if (period_cycles !== e.period || duty_cycles !== e.duty) begin
                    errors++;
                    $display("FAIL commit_value: got period=%0d duty=%0d, expected period=%0d duty=%0d",
                             period_cycles, duty_cycles, e.period, e.duty);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [31:0] d);
        cfg_t e;
        e.period = p;
        e.duty   = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (tb_enable !== 1'b0 || cfg_ready !== 1'b1 || update_pending !== 1'b0 || update_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got en=%b rdy=%b pend=%b done=%b, expected 0 1 0 0",
                     tb_enable, cfg_ready, update_pending, update_done);
        end
        checks++;
        if (period_cycles !== 32'd5000 || duty_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_values: got period=%0d duty=%0d, expected 5000 0", period_cycles, duty_cycles);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_stopped_commit();
        cfg_valid  = 1'b1;
        cfg_period = 32'd100;
        cfg_duty   = 32'd40;
        push_exp(32'd100, 32'd40);
        step();
        cfg_valid = 1'b0;
        checks++;
        if (period_cycles !== 32'd100 || duty_cycles !== 32'd40 || update_done !== 1'b1 || tb_enable !== 1'b0) begin
            errors++;
            $display("FAIL stopped_commit: got period=%0d duty=%0d done=%b en=%b, expected 100 40 1 0",
                     period_cycles, duty_cycles, update_done, tb_enable);
        end
        step();
        checks++;
        if (update_done !== 1'b0) begin
            errors++;
            $display("FAIL stopped_done_width: got done=%b, expected 0", update_done);
        end
    endtask

    task automatic test_run_update();
        enable_req = 1'b1;
        step();
        checks++;
        if (tb_enable !== 1'b1 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL enable_latency: got en=%b rdy=%b, expected 1 1", tb_enable, cfg_ready);
        end
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        cfg_valid  = 1'b1;
        cfg_period = 32'd50;
        cfg_duty   = 32'd20;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (update_pending !== 1'b1 || cfg_ready !== PEND_READY || period_cycles !== 32'd100 || duty_cycles !== 32'd40) begin
            errors++;
            $display("FAIL run_shadow: got pend=%b rdy=%b period=%0d duty=%0d, expected 1 %b 100 40",
                     update_pending, cfg_ready, period_cycles, duty_cycles, PEND_READY);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (update_pending !== 1'b1 || period_cycles !== 32'd100) begin
                errors++;
                $display("FAIL run_hold: got pend=%b period=%0d, expected 1 100", update_pending, period_cycles);
            end
        end
        period_end = 1'b1;
        push_exp(32'd50, 32'd20);
        step();
        period_end = 1'b0;
        checks++;
        if (period_cycles !== 32'd50 || duty_cycles !== 32'd20 || update_done !== 1'b1 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL run_commit: got period=%0d duty=%0d done=%b pend=%b, expected 50 20 1 0",
                     period_cycles, duty_cycles, update_done, update_pending);
        end
        step();
        checks++;
        if (update_done !== 1'b0 || tb_enable !== 1'b1) begin
            errors++;
            $display("FAIL run_after_commit: got done=%b en=%b, expected 0 1", update_done, tb_enable);
        end
    endtask

    task automatic test_clamp();
        enable_req = 1'b0;
        step();
        checks++;
        if (tb_enable !== 1'b0) begin
            errors++;
            $display("FAIL disable_latency: got en=%b, expected 0", tb_enable);
        end
        cfg_valid  = 1'b1;
        cfg_period = 32'd0;
        cfg_duty   = 32'd300;
        push_exp(32'd0, 32'd300);
        step();
        checks++;
        if (period_cycles !== 32'd0 || duty_cycles !== 32'd300) begin
            errors++;
            $display("FAIL clamp_period0: got period=%0d duty=%0d, expected 0 300", period_cycles, duty_cycles);
        end
        cfg_period = 32'd1;
        cfg_duty   = 32'd9;
        push_exp(32'd1, 32'd2);
        step();
        checks++;
        if (period_cycles !== 32'd1 || duty_cycles !== 32'd2) begin
            errors++;
            $display("FAIL clamp_period1: got period=%0d duty=%0d, expected 1 2", period_cycles, duty_cycles);
        end
        cfg_period = 32'd100;
        cfg_duty   = 32'd150;
        push_exp(32'd100, 32'd100);
        step();
        cfg_valid = 1'b0;
        checks++;
        if (period_cycles !== 32'd100 || duty_cycles !== 32'd100 || update_done !== 1'b1) begin
            errors++;
            $display("FAIL clamp_over: got period=%0d duty=%0d done=%b, expected 100 100 1",
                     period_cycles, duty_cycles, update_done);
        end
        period_end = 1'b1;
        step();
        period_end = 1'b0;
        step();
    endtask

    task automatic test_coincident();
        enable_req = 1'b1;
        step();
        cfg_valid  = 1'b1;
        cfg_period = 32'd80;
        cfg_duty   = 32'd30;
        period_end = 1'b1;
        step();
        cfg_valid  = 1'b0;
        period_end = 1'b0;
        checks++;
        if (update_pending !== 1'b1 || period_cycles !== 32'd100 || update_done !== 1'b0) begin
            errors++;
            $display("FAIL coincident_shadow: got pend=%b period=%0d done=%b, expected 1 100 0",
                     update_pending, period_cycles, update_done);
        end
`ifdef PWM_CFG_SEQ_OVERWRITE_EN
        cfg_valid  = 1'b1;
        cfg_period = 32'd70;
        cfg_duty   = 32'd10;
        step();
        checks++;
        if (cfg_ready !== 1'b1 || update_pending !== 1'b1 || period_cycles !== 32'd100) begin
            errors++;
            $display("FAIL overwrite_accept: got rdy=%b pend=%b period=%0d, expected 1 1 100",
                     cfg_ready, update_pending, period_cycles);
        end
        cfg_period = 32'd60;
        cfg_duty   = 32'd5;
        period_end = 1'b1;
        push_exp(32'd60, 32'd5);
        step();
        cfg_valid  = 1'b0;
        period_end = 1'b0;
        checks++;
        if (period_cycles !== 32'd60 || duty_cycles !== 32'd5 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL overwrite_commit: got period=%0d duty=%0d pend=%b, expected 60 5 0",
                     period_cycles, duty_cycles, update_pending);
        end
`else
        cfg_valid  = 1'b1;
        cfg_period = 32'd70;
        cfg_duty   = 32'd10;
        step();
        step();
        checks++;
        if (cfg_ready !== 1'b0 || update_pending !== 1'b1 || period_cycles !== 32'd100) begin
            errors++;
            $display("FAIL pending_stall: got rdy=%b pend=%b period=%0d, expected 0 1 100",
                     cfg_ready, update_pending, period_cycles);
        end
        period_end = 1'b1;
        push_exp(32'd80, 32'd30);
        step();
        period_end = 1'b0;
        checks++;
        if (period_cycles !== 32'd80 || duty_cycles !== 32'd30 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL coincident_commit: got period=%0d duty=%0d rdy=%b, expected 80 30 1",
                     period_cycles, duty_cycles, cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (update_pending !== 1'b1 || period_cycles !== 32'd80) begin
            errors++;
            $display("FAIL stalled_accept: got pend=%b period=%0d, expected 1 80", update_pending, period_cycles);
        end
        period_end = 1'b1;
        push_exp(32'd70, 32'd10);
        step();
        period_end = 1'b0;
        checks++;
        if (period_cycles !== 32'd70 || duty_cycles !== 32'd10) begin
            errors++;
            $display("FAIL stalled_commit: got period=%0d duty=%0d, expected 70 10", period_cycles, duty_cycles);
        end
`endif
        step();
    endtask

    task automatic test_drop_enable();
        cfg_valid  = 1'b1;
        cfg_period = 32'd40;
        cfg_duty   = 32'd50;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (update_pending !== 1'b1) begin
            errors++;
            $display("FAIL drop_pending: got pend=%b, expected 1", update_pending);
        end
        enable_req = 1'b0;
        push_exp(32'd40, 32'd40);
        step();
        checks++;
        if (tb_enable !== 1'b0 || period_cycles !== 32'd40 || duty_cycles !== 32'd40 ||
            update_done !== 1'b1 || update_pending !== 1'b0) begin
            errors++;
            $display("FAIL drop_commit: got en=%b period=%0d duty=%0d done=%b pend=%b, expected 0 40 40 1 0",
                     tb_enable, period_cycles, duty_cycles, update_done, update_pending);
        end
        step();
    endtask

    task automatic test_reset_pending();
        enable_req = 1'b1;
        step();
        cfg_valid  = 1'b1;
        cfg_period = 32'd30;
        cfg_duty   = 32'd10;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (update_pending !== 1'b1 || tb_enable !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got pend=%b en=%b, expected 1 1", update_pending, tb_enable);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tb_enable !== 1'b0 || cfg_ready !== 1'b1 || update_pending !== 1'b0 || update_done !== 1'b0 ||
            period_cycles !== 32'd5000 || duty_cycles !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got en=%b rdy=%b pend=%b done=%b period=%0d duty=%0d, expected 0 1 0 0 5000 0",
                     tb_enable, cfg_ready, update_pending, update_done, period_cycles, duty_cycles);
        end
        enable_req = 1'b0;
        period_end = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (update_done !== 1'b0 || period_cycles !== 32'd5000 || update_pending !== 1'b0) begin
                errors++;
                $display("FAIL post_reset: got done=%b period=%0d pend=%b, expected 0 5000 0",
                         update_done, period_cycles, update_pending);
            end
        end
        period_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stopped_commit();
        test_run_update();
        test_clamp();
        test_coincident();
        test_drop_enable();
        test_reset_pending();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding commits, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
